fence_t_seq: RTL and testbench

FENCE_T_SEQ -- requirements
Module: fence_t_seq

---
 rtl/fence_t_seq.sv | 105 ++++++++++
 tb/tb_fence_t_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fence_t_seq.sv
`default_nettype none
// fence_t_seq: constant-time fence.t sequencer. Issues one flush command, then
// holds for at least pad cycles and until the dcache flush is acknowledged.
module fence_t_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fence_t_req_i,
  input  logic [9:0]  fence_t_mask_i,
  input  logic [9:0]  fence_t_pad_i,
  output logic        fence_t_ready_o,
  output logic [19:0] fence_t_o,
  input  logic        flush_dcache_ack_i,
  output logic        busy_o,
  output logic        fence_t_done_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [9:0] COUNT_MAX = 10'h3FF;

  logic [1:0] state;
  logic [1:0] next_state;
  logic [9:0] mask_q;
  logic [9:0] pad_q;
  logic [9:0] counter;
  logic       ack_seen;
  logic       dcache_ack;
  logic       wait_exit;

  // The ack only counts when this fence actually asked for a dcache flush.
  assign dcache_ack = flush_dcache_ack_i & mask_q[4];
  assign wait_exit  = (ack_seen | dcache_ack) & (counter >= pad_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (fence_t_req_i) next_state = FLUSH;
      FLUSH:   next_state = WAIT;
      WAIT:    if (wait_exit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q   <= '0;
      pad_q    <= '0;
      counter  <= '0;
      ack_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fence_t_req_i) begin
            mask_q   <= fence_t_mask_i;
            pad_q    <= fence_t_pad_i;
            counter  <= '0;
            ack_seen <= 1'b0;
          end
        end
        FLUSH: begin
          counter  <= '0;
          ack_seen <= ~mask_q[4] | dcache_ack;
        end
        WAIT: begin
          if (dcache_ack) ack_seen <= 1'b1;
          // Saturate rather than wrap so a huge pad can never be re-satisfied early.
          if (!wait_exit && (counter != COUNT_MAX)) counter <= counter + 10'd1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    fence_t_ready_o = 1'b0;
    fence_t_o       = '0;
    busy_o          = 1'b1;
    fence_t_done_o  = 1'b0;
    case (state)
      IDLE: begin
        fence_t_ready_o = 1'b1;
        busy_o          = 1'b0;
      end
      FLUSH:   fence_t_o = {pad_q, mask_q};
      DONE:    fence_t_done_o = 1'b1;
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fence_t_seq.sv
`default_nettype none
// tb_fence_t_seq: scoreboard bench; the driver predicts command/done timing,
// the negedge monitor pops and compares when the DUT produces them.
module tb_fence_t_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [9:0]  mask = '0;
  logic [9:0]  pad = '0;
  logic        ready;
  logic [19:0] fence_t;
  logic        ack = 1'b0;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int idle_from = 0;
  int cur_flush = -1;
  int cur_done = -1;
  bit mon_en = 1'b0;
  bit prev_busy = 1'b0;

  typedef struct {
    int          at;
    logic [19:0] val;
  } cmd_t;

  cmd_t cmd_q[$];
  int   done_q[$];

  fence_t_seq dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .fence_t_req_i      (req),
    .fence_t_mask_i     (mask),
    .fence_t_pad_i      (pad),
    .fence_t_ready_o    (ready),
    .fence_t_o          (fence_t),
    .flush_dcache_ack_i (ack),
    .busy_o             (busy),
    .fence_t_done_o     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: cycle-level busy/ready model plus scoreboard pops on DUT events.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      exp_busy = rst_n && (cyc >= cur_flush) && (cyc <= cur_done);
      check("busy", busy, exp_busy);
      check("ready", ready, !exp_busy);
      if (busy && !prev_busy) begin
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", 1, 0);
        end else begin
          cmd_t e;
          e = cmd_q.pop_front();
          check("cmd_value", fence_t, e.val);
          check("cmd_cycle", cyc, e.at);
        end
      end else begin
        check("cmd_zero", fence_t, 0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          int d;
          d = done_q.pop_front();
          check("done_cycle", cyc, d);
        end
      end
      prev_busy = busy;
    end
  end

  // One fence: accepted at the first predicted-idle cycle; ack high for
  // ack_len cycles starting ack_rel cycles after the accept.
  task automatic fence(input logic [9:0] m, input logic [9:0] p, input int ack_rel, input int ack_len);
    int acc, lat, dn;
    while (cyc < idle_from) next_cycle();
    req = 1'b1; mask = m; pad = p; ack = 1'b0;
    acc = cyc;
    lat = 3 + int'(p);
    if (m[4] && (ack_rel + 1 > lat)) lat = ack_rel + 1;
    dn = acc + lat;
    cmd_q.push_back('{acc + 1, {p, m}});
    done_q.push_back(dn);
    cur_flush = acc + 1;
    cur_done = dn;
    idle_from = dn + 1;
    for (int r = 1; r <= lat; r++) begin
      next_cycle();
      req = 1'b0;
      ack = (r >= ack_rel) && (r < ack_rel + ack_len);
    end
    next_cycle();
    ack = 1'b0;
  endtask

  initial begin
    int acc;
    mon_en = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_counter", dut.counter, 0);
    check("rst_mask", dut.mask_q, 0);
    check("rst_pad", dut.pad_q, 0);
    check("rst_ack_seen", dut.ack_seen, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    idle_from = cyc + 1;

    fence(10'h001, 10'd5, 0, 0);      // pad-only
    fence(10'h0A0, 10'd0, 2, 1);      // zero pad, ack ignored
    fence(10'h010, 10'd2, 10, 1);     // late ack dominates
    fence(10'h010, 10'd2, 2, 1);      // early ack, pad dominates
    fence(10'h010, 10'd0, 1, 1);      // ack during FLUSH
    fence(10'h000, 10'd0, 0, 0);      // empty mask, zero pad
    ack = 1'b1;                       // ack in IDLE must not pre-satisfy the next fence
    next_cycle();
    fence(10'h010, 10'd0, 6, 1);
    for (int i = 0; i < 6; i++) begin
      logic [9:0] m;
      m = 10'($urandom_range(0, 1023));
      fence(m, 10'($urandom_range(0, 6)), int'($urandom_range(1, 12)), int'($urandom_range(1, 3)));
    end

    // Busy rejection: second request held from FLUSH until the next IDLE.
    while (cyc < idle_from) next_cycle();
    acc = cyc;
    req = 1'b1; mask = 10'h001; pad = 10'd1;
    cmd_q.push_back('{acc + 1, {10'd1, 10'h001}});
    done_q.push_back(acc + 4);
    cur_flush = acc + 1;
    cur_done = acc + 4;
    next_cycle();
    mask = 10'h3C0; pad = 10'd0;
    for (int i = 0; i < 4; i++) next_cycle();
    cmd_q.push_back('{acc + 6, {10'd0, 10'h3C0}});
    done_q.push_back(acc + 8);
    cur_flush = acc + 6;
    cur_done = acc + 8;
    next_cycle();
    req = 1'b0;
    idle_from = acc + 9;

    // Saturation, then asynchronous reset in the middle of WAIT.
    while (cyc < idle_from) next_cycle();
    acc = cyc;
    req = 1'b1; mask = 10'h010; pad = 10'd1023;
    cmd_q.push_back('{acc + 1, {10'd1023, 10'h010}});
    cur_flush = acc + 1;
    cur_done = 1 << 30;
    next_cycle();
    req = 1'b0;
    for (int i = 0; i < 1100; i++) next_cycle();
    check("sat_counter", dut.counter, 10'h3FF);
    check("sat_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", ready, 1);
    check("arst_fence", fence_t, 0);
    check("arst_done", done, 0);
    check("arst_counter", dut.counter, 0);
    check("arst_mask", dut.mask_q, 0);
    check("arst_pad", dut.pad_q, 0);
    check("arst_ack_seen", dut.ack_seen, 0);
    cur_done = -1;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) next_cycle();
    idle_from = cyc;
    fence(10'h010, 10'd0, 1, 1);      // recovery after abort

    for (int i = 0; i < 3; i++) next_cycle();
    check("cmd_q_empty", cmd_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
